// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan_ctrl
// Purpose  : 4x4 keypad row scanner with press/release debounce and a key
//            buffer behind a valid/ack handshake. Defining KEYPAD_FIFO_EN
//            swaps the single-register buffer for a 4-entry FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scan_ctrl #(
    parameter int SETTLE_CYC   = 16,
    parameter int DEBOUNCE_CYC = 20000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_scan_en,
    input  logic [3:0] i_col_n,
    output logic [3:0] o_row_n,
    input  logic       i_key_ack,
    output logic       o_key_valid,
    output logic [3:0] o_key_code,
    output logic       o_pressed,
    output logic       o_overrun
);

    localparam int CNT_MAX = (SETTLE_CYC > DEBOUNCE_CYC) ? SETTLE_CYC : DEBOUNCE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DRIVE    = 3'd1,
        S_SAMPLE   = 3'd2,
        S_DEBOUNCE = 3'd3,
        S_PRESS    = 3'd4,
        S_RELEASE  = 3'd5
    } state_t;

    logic [3:0]       sync1_q, col_s_q;
    state_t           state_q, state_d;
    logic [1:0]       row_q, row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       pat_q, pat_d;
    logic             push;
    logic             single_low;
    logic [1:0]       col_idx;
    logic [3:0]       push_code;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync1_q <= 4'hF;
            col_s_q <= 4'hF;
        end else begin
            sync1_q <= i_col_n;
            col_s_q <= sync1_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            row_q   <= 2'd0;
            cnt_q   <= '0;
            pat_q   <= 4'hF;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
        end
    end

    // A pattern with several low columns is a ghost/multi-key and yields no code.
    always_comb begin
        col_idx    = 2'd0;
        single_low = 1'b1;
        case (pat_q)
            4'b1110: col_idx = 2'd0;
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: single_low = 1'b0;
        endcase
    end

    assign push_code = {row_q, col_idx};

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        push    = 1'b0;
        if (!i_scan_en) begin
            state_d = S_IDLE;
            row_d   = 2'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_DRIVE;
                    cnt_d   = '0;
                end
                S_DRIVE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = S_SAMPLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    cnt_d = '0;
                    if (col_s_q != 4'hF) begin
                        pat_d   = col_s_q;
                        state_d = S_DEBOUNCE;
                    end else begin
                        row_d   = row_q + 2'd1;
                        state_d = S_DRIVE;
                    end
                end
                S_DEBOUNCE: begin
                    if (col_s_q != pat_q) begin
                        row_d   = row_q + 2'd1;
                        state_d = S_DRIVE;
                        cnt_d   = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d = S_PRESS;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_PRESS: begin
                    push    = single_low;
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                end
                S_RELEASE: begin
                    // Any bounce back to a low column restarts the release count.
                    if (col_s_q != 4'hF) begin
                        cnt_d = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        row_d   = row_q + 2'd1;
                        state_d = S_DRIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    row_d   = 2'd0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign o_row_n   = (state_q == S_IDLE) ? 4'hF : ~(4'b0001 << row_q);
    assign o_pressed = (state_q == S_PRESS) || (state_q == S_RELEASE);

`ifdef KEYPAD_FIFO_EN
    logic [3:0] mem_q [4];
    logic [1:0] wr_q, rd_q;
    logic [2:0] fill_q;
    logic       overrun_q;
    logic       empty, full, pop, do_push, drop;

    assign empty   = (fill_q == 3'd0);
    assign full    = (fill_q == 3'd4);
    assign pop     = i_key_ack && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 4; i++) mem_q[i] <= 4'h0;
            wr_q      <= 2'd0;
            rd_q      <= 2'd0;
            fill_q    <= 3'd0;
            overrun_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_code;
                wr_q        <= wr_q + 2'd1;
            end
            if (pop) rd_q <= rd_q + 2'd1;
            case ({do_push, pop})
                2'b10:   fill_q <= fill_q + 3'd1;
                2'b01:   fill_q <= fill_q - 3'd1;
                default: fill_q <= fill_q;
            endcase
            if (pop)       overrun_q <= 1'b0;
            else if (drop) overrun_q <= 1'b1;
        end
    end

    assign o_key_valid = !empty;
    assign o_key_code  = empty ? 4'h0 : mem_q[rd_q];
    assign o_overrun   = overrun_q;
`else
    logic       valid_q, overrun_q;
    logic [3:0] code_q;
    logic       ack_take;

    assign ack_take = i_key_ack && valid_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_q   <= 1'b0;
            code_q    <= 4'h0;
            overrun_q <= 1'b0;
        end else begin
            if (push) begin
                code_q  <= push_code;
                valid_q <= 1'b1;
            end else if (ack_take) begin
                code_q  <= 4'h0;
                valid_q <= 1'b0;
            end
            // Overwrite counts as lost only when the old code was not consumed.
            if (ack_take)             overrun_q <= 1'b0;
            else if (push && valid_q) overrun_q <= 1'b1;
        end
    end

    assign o_key_valid = valid_q;
    assign o_key_code  = code_q;
    assign o_overrun   = overrun_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scan_ctrl
// Purpose  : Directed bench for keypad_scan_ctrl (SETTLE_CYC=4, DEBOUNCE_CYC=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scan_en;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic        key_ack;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        pressed;
    logic        overrun;
    logic [15:0] keys;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    keypad_scan_ctrl #(
        .SETTLE_CYC   (4),
        .DEBOUNCE_CYC (8)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_scan_en   (scan_en),
        .i_col_n     (col_n),
        .o_row_n     (row_n),
        .i_key_ack   (key_ack),
        .o_key_valid (key_valid),
        .o_key_code  (key_code),
        .o_pressed   (pressed),
        .o_overrun   (overrun)
    );

    // Keypad matrix: a held key pulls its column low while its row is driven.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench at the negedge right after reset release (edge 0).
    task automatic apply_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        scan_en = 1'b1; key_ack = 1'b0; keys = 16'h0001;
        rst_n = 1'b0; step(3); rst_n = 1'b1;
        step(25);
        total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid: got %b want 1", key_valid); end
        total++; if (pressed !== 1'b1) begin bad++; $display("FAIL pre_reset_pressed: got %b want 1", pressed); end
        rst_n = 1'b0; step(1);
        total++; if (row_n !== 4'hF) begin bad++; $display("FAIL rst_row: got %h want F", row_n); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", key_valid); end
        total++; if (key_code !== 4'h0) begin bad++; $display("FAIL rst_code: got %h want 0", key_code); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun: got %b want 0", overrun); end
        total++; if (pressed !== 1'b0) begin bad++; $display("FAIL rst_pressed: got %b want 0", pressed); end
        keys = 16'h0000; step(2); rst_n = 1'b1;
        total++; if (row_n !== 4'hF) begin bad++; $display("FAIL idle_row: got %h want F", row_n); end
        step(1);
        total++; if (row_n !== 4'hE) begin bad++; $display("FAIL scan_row0: got %h want E", row_n); end
        step(4);
        total++; if (row_n !== 4'hE) begin bad++; $display("FAIL scan_row0_sample: got %h want E", row_n); end
        step(1);
        total++; if (row_n !== 4'hD) begin bad++; $display("FAIL scan_row1: got %h want D", row_n); end
        step(5);
        total++; if (row_n !== 4'hB) begin bad++; $display("FAIL scan_row2: got %h want B", row_n); end
        step(5);
        total++; if (row_n !== 4'h7) begin bad++; $display("FAIL scan_row3: got %h want 7", row_n); end
        step(5);
        total++; if (row_n !== 4'hE) begin bad++; $display("FAIL scan_wrap: got %h want E", row_n); end
    endtask

    task automatic test_single_key();
        keys = 16'h0200;
        apply_reset();
        step(23);
        total++; if (pressed !== 1'b0) begin bad++; $display("FAIL k9_debouncing_pressed: got %b want 0", pressed); end
        step(1);
        total++; if (pressed !== 1'b1) begin bad++; $display("FAIL k9_press_state: got %b want 1", pressed); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL k9_valid_early: got %b want 0", key_valid); end
        step(1);
        total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL k9_valid: got %b want 1", key_valid); end
        total++; if (key_code !== 4'd9) begin bad++; $display("FAIL k9_code: got %0d want 9", key_code); end
        step(20);
        total++; if (key_code !== 4'd9 || key_valid !== 1'b1) begin bad++; $display("FAIL k9_hold: got v=%b c=%0d want v=1 c=9", key_valid, key_code); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL k9_no_repeat: got overrun=%b want 0", overrun); end
        total++; if (pressed !== 1'b1) begin bad++; $display("FAIL k9_held_pressed: got %b want 1", pressed); end
        key_ack = 1'b1; step(1); key_ack = 1'b0;
        total++; if (key_valid !== 1'b0 || key_code !== 4'd0) begin bad++; $display("FAIL k9_ack: got v=%b c=%0d want v=0 c=0", key_valid, key_code); end
        keys = 16'h0000;
        step(9);
        total++; if (pressed !== 1'b1) begin bad++; $display("FAIL k9_release_early: got %b want 1", pressed); end
        step(1);
        total++; if (pressed !== 1'b0) begin bad++; $display("FAIL k9_released: got %b want 0", pressed); end
        total++; if (row_n !== 4'h7) begin bad++; $display("FAIL k9_next_row: got %h want 7", row_n); end
    endtask

    task automatic test_bounce();
        logic saw_p, saw_v;
        saw_p = 1'b0; saw_v = 1'b0;
        keys = 16'h0000;
        apply_reset();
        for (int j = 1; j <= 60; j++) begin
            step(1);
            if (j == 6) begin
                total++; if (row_n !== 4'hE) begin bad++; $display("FAIL bounce_debounce_row: got %h want E", row_n); end
            end
            if (j == 7) begin
                total++; if (row_n !== 4'hD) begin bad++; $display("FAIL bounce_advance_row: got %h want D", row_n); end
            end
            keys[0] = ((j % 5) >= 1) && ((j % 5) <= 3);
            saw_p |= pressed;
            saw_v |= key_valid;
        end
        keys = 16'h0000;
        total++; if (saw_p !== 1'b0) begin bad++; $display("FAIL bounce_pressed: got %b want 0", saw_p); end
        total++; if (saw_v !== 1'b0) begin bad++; $display("FAIL bounce_valid: got %b want 0", saw_v); end
    endtask

    task automatic test_multi_key();
        keys = 16'h0050;
        apply_reset();
        step(19);
        total++; if (pressed !== 1'b1) begin bad++; $display("FAIL ghost_pressed: got %b want 1", pressed); end
        step(2);
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL ghost_no_push: got %b want 0", key_valid); end
        keys = 16'h0000;
        step(10);
        total++; if (pressed !== 1'b0 || row_n !== 4'hB) begin bad++; $display("FAIL ghost_release: got p=%b row=%h want p=0 row=B", pressed, row_n); end
        keys = 16'h0080;
        step(28);
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL k7_early: got %b want 0", key_valid); end
        step(1);
        total++; if (key_valid !== 1'b1 || key_code !== 4'd7) begin bad++; $display("FAIL k7_code: got v=%b c=%0d want v=1 c=7", key_valid, key_code); end
    endtask

`ifdef KEYPAD_FIFO_EN
    task automatic press_release(input int k);
        int n;
        keys = 16'(1) << k;
        n = 0;
        while (pressed !== 1'b1 && n < 200) begin step(1); n++; end
        total++; if (pressed !== 1'b1) begin bad++; $display("FAIL press_timeout key %0d: got %b want 1", k, pressed); end
        keys = 16'h0000;
        n = 0;
        while (pressed !== 1'b0 && n < 200) begin step(1); n++; end
        total++; if (pressed !== 1'b0) begin bad++; $display("FAIL release_timeout key %0d: got %b want 0", k, pressed); end
    endtask

    task automatic test_overrun();
        keys = 16'h0000;
        apply_reset();
        for (int k = 0; k < 5; k++) press_release(k);
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL fifo_overrun: got %b want 1", overrun); end
        for (int i = 0; i < 4; i++) begin
            total++; if (key_valid !== 1'b1 || key_code !== 4'(i)) begin bad++; $display("FAIL fifo_pop%0d: got v=%b c=%0d want v=1 c=%0d", i, key_valid, key_code, i); end
            key_ack = 1'b1; step(1); key_ack = 1'b0;
        end
        total++; if (key_valid !== 1'b0 || key_code !== 4'd0) begin bad++; $display("FAIL fifo_empty: got v=%b c=%0d want v=0 c=0", key_valid, key_code); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL fifo_overrun_clr: got %b want 0", overrun); end
    endtask
`else
    task automatic test_overrun();
        keys = 16'h0008;
        apply_reset();
        step(15);
        total++; if (key_valid !== 1'b1 || key_code !== 4'd3) begin bad++; $display("FAIL k3_code: got v=%b c=%0d want v=1 c=3", key_valid, key_code); end
        keys = 16'h0000;
        step(10);
        total++; if (pressed !== 1'b0 || row_n !== 4'hD) begin bad++; $display("FAIL k3_release: got p=%b row=%h want p=0 row=D", pressed, row_n); end
        keys = 16'h1000;
        step(23);
        total++; if (key_code !== 4'd3 || overrun !== 1'b0) begin bad++; $display("FAIL k12_before: got c=%0d o=%b want c=3 o=0", key_code, overrun); end
        step(1);
        total++; if (key_code !== 4'd12 || key_valid !== 1'b1) begin bad++; $display("FAIL k12_code: got v=%b c=%0d want v=1 c=12", key_valid, key_code); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL k12_overrun: got %b want 1", overrun); end
        key_ack = 1'b1; step(1); key_ack = 1'b0;
        total++; if (overrun !== 1'b0 || key_valid !== 1'b0 || key_code !== 4'd0) begin bad++; $display("FAIL k12_ack: got o=%b v=%b c=%0d want 0 0 0", overrun, key_valid, key_code); end
        keys = 16'h0000;
    endtask
`endif

    task automatic test_scan_disable();
        keys = 16'h0001;
        apply_reset();
        step(10);
        total++; if (row_n !== 4'hE || pressed !== 1'b0) begin bad++; $display("FAIL dis_debounce: got row=%h p=%b want row=E p=0", row_n, pressed); end
        scan_en = 1'b0;
        step(1);
        total++; if (row_n !== 4'hF) begin bad++; $display("FAIL dis_row: got %h want F", row_n); end
        keys = 16'h0000;
        step(3);
        total++; if (key_valid !== 1'b0 || pressed !== 1'b0) begin bad++; $display("FAIL dis_no_push: got v=%b p=%b want 0 0", key_valid, pressed); end
        scan_en = 1'b1;
        step(1);
        total++; if (row_n !== 4'hE) begin bad++; $display("FAIL reen_row0: got %h want E", row_n); end
        step(5);
        total++; if (row_n !== 4'hD) begin bad++; $display("FAIL reen_row1: got %h want D", row_n); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reen_valid: got %b want 0", key_valid); end
    endtask

    initial begin
        rst_n = 1'b0; scan_en = 1'b0; key_ack = 1'b0; keys = 16'h0000;
        test_reset();
        test_single_key();
        test_bounce();
        test_multi_key();
        test_overrun();
        test_scan_disable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
